// File: rtl/dm_access_unit.sv
// MEM-stage load/store initiator: aligned loads with sign/zero extension,
// single-cycle word stores, and two-cycle read-modify-write for sub-word stores.
module dm_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic [2:0]        Op,
    input  logic [31:0]       Addr,
    input  logic [31:0]       StoreData,
    output logic              Busy,
    output logic              LoadValid,
    output logic [31:0]       LoadData,
    output logic              AddrErr,
    output logic [ADDR_W-1:0] DmA,
    output logic [31:0]       DmWD,
    output logic              DmWe,
    input  logic [31:0]       DmRD
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic [0:0]        state_q, state_d;
    logic [31:0]       merge_q, merge_d;
    logic [ADDR_W-1:0] saved_addr_q, saved_addr_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              addr_err_q, addr_err_d;

    logic        misaligned;
    logic        is_load;
    logic        is_sub_store;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extracted;
    logic [31:0] merged;

    // Upper address bits alias onto the same memory and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[31:ADDR_W+2];

    always_comb begin
        misaligned = 1'b0;
        case (Op)
            OP_LW, OP_SW:         misaligned = (Addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = Addr[0];
            default:              misaligned = 1'b0;
        endcase
        is_load      = (Op <= OP_LBU);
        is_sub_store = (Op == OP_SH) || (Op == OP_SB);

        byte_sel = DmRD[7:0];
        case (Addr[1:0])
            2'd0:    byte_sel = DmRD[7:0];
            2'd1:    byte_sel = DmRD[15:8];
            2'd2:    byte_sel = DmRD[23:16];
            default: byte_sel = DmRD[31:24];
        endcase
        half_sel = Addr[1] ? DmRD[31:16] : DmRD[15:0];

        extracted = DmRD;
        case (Op)
            OP_LH:   extracted = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  extracted = {16'h0000, half_sel};
            OP_LB:   extracted = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  extracted = {24'h000000, byte_sel};
            default: extracted = DmRD;
        endcase

        merged = DmRD;
        if (Op == OP_SH) begin
            if (Addr[1]) merged[31:16] = StoreData[15:0];
            else         merged[15:0]  = StoreData[15:0];
        end else begin
            case (Addr[1:0])
                2'd0:    merged[7:0]   = StoreData[7:0];
                2'd1:    merged[15:8]  = StoreData[7:0];
                2'd2:    merged[23:16] = StoreData[7:0];
                default: merged[31:24] = StoreData[7:0];
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        saved_addr_d = saved_addr_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        DmA          = Addr[ADDR_W+1:2];
        DmWD         = StoreData;
        DmWe         = 1'b0;
        Busy         = 1'b0;

        if (state_q == ST_WRITE) begin
            DmA     = saved_addr_q;
            DmWD    = merge_q;
            DmWe    = 1'b1;
            state_d = ST_IDLE;
        end else if (Req) begin
            if (misaligned) begin
                addr_err_d = 1'b1;
            end else if (is_load) begin
                load_data_d  = extracted;
                load_valid_d = 1'b1;
            end else if (Op == OP_SW) begin
                DmWe = 1'b1;
            end else if (is_sub_store) begin
                Busy         = 1'b1;
                merge_d      = merged;
                saved_addr_d = Addr[ADDR_W+1:2];
                state_d      = ST_WRITE;
            end
        end

        // Reset must kill an in-flight write before the flops settle.
        if (Reset) begin
            DmWe = 1'b0;
            Busy = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            merge_q      <= '0;
            saved_addr_q <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            merge_q      <= merge_d;
            saved_addr_q <= saved_addr_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign LoadValid = load_valid_q;
    assign LoadData  = load_data_q;
    assign AddrErr   = addr_err_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: behavioural data memory plus load/write scoreboards
// checked against hand-derived expected values.
module tb_dm_access_unit;

    localparam int ADDR_W = 10;

    logic              Clk;
    logic              Reset;
    logic              Req;
    logic [2:0]        Op;
    logic [31:0]       Addr;
    logic [31:0]       StoreData;
    logic              Busy;
    logic              LoadValid;
    logic [31:0]       LoadData;
    logic              AddrErr;
    logic [ADDR_W-1:0] DmA;
    logic [31:0]       DmWD;
    logic              DmWe;
    logic [31:0]       DmRD;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] load_q [$];
    logic [31:0] write_q [$];
    int checks = 0;
    int passes = 0;

    dm_access_unit #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr),
        .StoreData(StoreData), .Busy(Busy), .LoadValid(LoadValid),
        .LoadData(LoadData), .AddrErr(AddrErr), .DmA(DmA), .DmWD(DmWD),
        .DmWe(DmWe), .DmRD(DmRD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign DmRD = mem[DmA];
    always @(posedge Clk) if (DmWe) mem[DmA] <= DmWD;

    task automatic test_reset();
        Reset = 1'b1; Req = 1'b0; Op = 3'd0; Addr = '0; StoreData = '0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if ({LoadValid, AddrErr, LoadData} !== 34'd0)
            $display("FAIL reset_regs: got %b/%b/%h want 0/0/0", LoadValid, AddrErr, LoadData);
        else passes++;
        checks++; if ({Busy, DmWe} !== 2'b00)
            $display("FAIL reset_comb: got busy=%b we=%b want 0/0", Busy, DmWe);
        else passes++;
        @(negedge Clk); Reset = 1'b0;
    endtask

    task automatic do_load(input string name, input logic [2:0] op,
                           input logic [31:0] addr, input logic [ADDR_W-1:0] exp_a,
                           input logic [31:0] exp_d);
        logic [31:0] want;
        @(negedge Clk);
        Req = 1'b1; Op = op; Addr = addr;
        load_q.push_back(exp_d);
        #1;
        checks++; if ({DmA, Busy, DmWe} !== {exp_a, 2'b00})
            $display("FAIL %s_port: got a=%0d busy=%b we=%b want a=%0d 0 0", name, DmA, Busy, DmWe, exp_a);
        else passes++;
        @(posedge Clk); #1;
        Req = 1'b0;
        checks++;
        if (LoadValid !== 1'b1 || AddrErr !== 1'b0 || load_q.size() == 0) begin
            $display("FAIL %s_valid: got valid=%b err=%b want 1/0", name, LoadValid, AddrErr);
            if (load_q.size() != 0) void'(load_q.pop_front());
        end else begin
            want = load_q.pop_front();
            if (LoadData !== want)
                $display("FAIL %s_data: got %h want %h", name, LoadData, want);
            else passes++;
        end
    endtask

    task automatic do_sw(input string name, input logic [31:0] addr, input logic [31:0] data,
                         input logic [ADDR_W-1:0] exp_a);
        @(negedge Clk);
        Req = 1'b1; Op = 3'd5; Addr = addr; StoreData = data;
        write_q.push_back(data);
        #1;
        checks++;
        if (DmWe !== 1'b1 || Busy !== 1'b0 || DmA !== exp_a || write_q.size() == 0) begin
            $display("FAIL %s_port: got we=%b busy=%b a=%0d want 1/0/%0d", name, DmWe, Busy, DmA, exp_a);
            if (write_q.size() != 0) void'(write_q.pop_front());
        end else if (DmWD !== write_q[0]) begin
            $display("FAIL %s_wd: got %h want %h", name, DmWD, write_q[0]);
            void'(write_q.pop_front());
        end else begin
            void'(write_q.pop_front());
            passes++;
        end
        @(posedge Clk); #1;
        Req = 1'b0;
        checks++; if (LoadValid !== 1'b0 || AddrErr !== 1'b0)
            $display("FAIL %s_novalid: got valid=%b err=%b want 0/0", name, LoadValid, AddrErr);
        else passes++;
    endtask

    // Read phase then write phase; abort_in_write asserts Reset during WRITE.
    task automatic do_sub_store(input string name, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [ADDR_W-1:0] exp_a,
                                input logic [31:0] exp_word, input bit abort_in_write);
        @(negedge Clk);
        Req = 1'b1; Op = op; Addr = addr; StoreData = data;
        write_q.push_back(exp_word);
        #1;
        checks++; if ({Busy, DmWe, DmA} !== {2'b10, exp_a})
            $display("FAIL %s_read: got busy=%b we=%b a=%0d want 1/0/%0d", name, Busy, DmWe, DmA, exp_a);
        else passes++;
        @(posedge Clk); #1;
        if (abort_in_write) begin
            void'(write_q.pop_front());
            @(negedge Clk);
            Reset = 1'b1; Req = 1'b0;
            #1;
            checks++; if ({DmWe, Busy, LoadValid, AddrErr} !== 4'b0000 || LoadData !== 32'd0)
                $display("FAIL %s_abort: got we=%b busy=%b v=%b e=%b d=%h want all 0",
                         name, DmWe, Busy, LoadValid, AddrErr, LoadData);
            else passes++;
            @(posedge Clk); #1;
            checks++; if (DmWe !== 1'b0)
                $display("FAIL %s_abort_we: got %b want 0", name, DmWe);
            else passes++;
            @(negedge Clk); Reset = 1'b0;
        end else begin
            checks++;
            if (DmWe !== 1'b1 || Busy !== 1'b0 || DmA !== exp_a || write_q.size() == 0) begin
                $display("FAIL %s_write: got we=%b busy=%b a=%0d want 1/0/%0d", name, DmWe, Busy, DmA, exp_a);
                if (write_q.size() != 0) void'(write_q.pop_front());
            end else if (DmWD !== write_q[0]) begin
                $display("FAIL %s_wd: got %h want %h", name, DmWD, write_q[0]);
                void'(write_q.pop_front());
            end else begin
                void'(write_q.pop_front());
                passes++;
            end
            @(posedge Clk); #1;
            Req = 1'b0;
            checks++; if (DmWe !== 1'b0 || LoadValid !== 1'b0)
                $display("FAIL %s_done: got we=%b valid=%b want 0/0", name, DmWe, LoadValid);
            else passes++;
        end
    endtask

    task automatic do_misaligned(input string name, input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] held;
        held = LoadData;
        @(negedge Clk);
        Req = 1'b1; Op = op; Addr = addr; StoreData = 32'hCAFEF00D;
        #1;
        checks++; if ({DmWe, Busy} !== 2'b00)
            $display("FAIL %s_port: got we=%b busy=%b want 0/0", name, DmWe, Busy);
        else passes++;
        @(posedge Clk); #1;
        Req = 1'b0;
        checks++; if ({AddrErr, LoadValid, DmWe} !== 3'b100 || LoadData !== held)
            $display("FAIL %s_err: got err=%b valid=%b we=%b d=%h want 1/0/0 d=%h",
                     name, AddrErr, LoadValid, DmWe, LoadData, held);
        else passes++;
        @(posedge Clk); #1;
        checks++; if (AddrErr !== 1'b0)
            $display("FAIL %s_pulse: got err=%b want 0", name, AddrErr);
        else passes++;
    endtask

    task automatic test_loads();
        do_sw("preload", 32'h0000000C, 32'h8899AABB, 10'd3);
        do_load("lb",  3'd3, 32'h0000000D, 10'd3, 32'hFFFFFFAA);
        do_load("lbu", 3'd4, 32'h0000000D, 10'd3, 32'h000000AA);
        do_load("lh",  3'd1, 32'h0000000E, 10'd3, 32'hFFFF8899);
        do_load("lhu", 3'd2, 32'h0000000E, 10'd3, 32'h00008899);
        do_load("lw",  3'd0, 32'h0000000C, 10'd3, 32'h8899AABB);
        do_load("lb0", 3'd3, 32'h0000000C, 10'd3, 32'hFFFFFFBB);
        do_load("lbu3",3'd4, 32'h0000000F, 10'd3, 32'h00000088);
    endtask

    task automatic test_stores();
        do_sub_store("sb", 3'd7, 32'h0000000D, 32'h12345677, 10'd3, 32'h889977BB, 1'b0);
        do_load("lw_sb", 3'd0, 32'h0000000C, 10'd3, 32'h889977BB);
        do_sw("sw", 32'h00000010, 32'hDEADBEEF, 10'd4);
        do_load("lh_sw", 3'd1, 32'h00000012, 10'd4, 32'hFFFFDEAD);
        do_sub_store("sh", 3'd6, 32'h00000014, 32'hFFFF1234, 10'd5, 32'h00001234, 1'b0);
        do_load("lhu_sh", 3'd2, 32'h00000014, 10'd5, 32'h00001234);
        do_load("alias", 3'd0, 32'h1000000C, 10'd3, 32'h889977BB);
    endtask

    task automatic test_misaligned();
        do_misaligned("lw_mis", 3'd0, 32'h00000006);
        do_misaligned("sh_mis", 3'd6, 32'h00000005);
        do_misaligned("sw_mis", 3'd5, 32'h00000013);
        do_load("mem_kept", 3'd0, 32'h0000000C, 10'd3, 32'h889977BB);
    endtask

    task automatic test_reset_mid_rmw();
        do_sub_store("sh_rst", 3'd6, 32'h00000010, 32'h00005555, 10'd4, 32'hDEAD5555, 1'b1);
        do_load("lw_after_rst", 3'd0, 32'h00000010, 10'd4, 32'hDEADBEEF);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_reset_mid_rmw();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- MEM-stage load/store initiator for the pipelined CPU.
- Accepts one memory operation per request from the pipeline and drives the word-addressed data-memory port: 10-bit word address, 32-bit write data, write enable, combinational 32-bit read data.
- Performs byte/halfword extraction with sign or zero extension for loads.
- Performs sub-word stores as a two-cycle read-modify-write, stalling the pipeline during that sequence.
- Flags misaligned accesses.

Parameters:
- ADDR_W, 10, word-address width driven to data memory (byte address bits [ADDR_W+1:2]).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  valid memory operation present this cycle.
- Op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- Addr  in  32  byte address.
- StoreData  in  32  store source; SH uses bits [15:0], SB uses bits [7:0].
- Busy  out  1  stall request to pipeline (combinational).
- LoadValid  out  1  registered, 1-cycle pulse: LoadData valid.
- LoadData  out  32  registered, extended load result.
- AddrErr  out  1  registered, 1-cycle pulse: misaligned request.
- DmA  out  ADDR_W  word address to data memory.
- DmWD  out  32  write data to data memory.
- DmWe  out  1  write enable to data memory.
- DmRD  in  32  combinational read data from data memory.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; LoadData=0, LoadValid=0, AddrErr=0, merge register=0.
  - DmWe forced 0 and Busy forced 0 while Reset is high.
- States: IDLE, WRITE.
- Byte lanes (little-endian):
  - byte k = bits [8k+7:8k], k=Addr[1:0].
  - halfword = bits [16*Addr[1]+15 : 16*Addr[1]].
- Alignment:
  - LW/SW need Addr[1:0]=00.
  - LH/LHU/SH need Addr[0]=0.
  - Bytes are always aligned.
- Address range: Addr[31:ADDR_W+2] ignored; memory aliases, no error.
- IDLE, no Req: DmWe=0, DmA=Addr[ADDR_W+1:2], DmWD=StoreData, Busy=0; LoadValid and AddrErr go 0 next edge.
- IDLE, Req, misaligned:
  - DmWe=0, Busy=0, no state change.
  - Next edge: AddrErr=1, LoadValid=0, LoadData unchanged.
- IDLE, Req, aligned load:
  - DmA=Addr word.
  - Next edge: LoadData = extracted DmRD (LH/LB sign-extend, LHU/LBU zero-extend, LW whole word), LoadValid=1.
  - Latency 1 cycle; Busy=0.
- IDLE, Req, aligned SW: DmWe=1, DmWD=StoreData this cycle; Busy=0; single cycle.
- IDLE, Req, aligned SH/SB (read phase):
  - DmA=Addr word, DmWe=0, Busy=1.
  - Next edge: merge register = DmRD with the selected lane replaced by StoreData low bits; saved word address latched; state->WRITE.
- WRITE:
  - DmA=saved address, DmWD=merge register, DmWe=1, Busy=0.
  - Req/Op/Addr ignored; next edge ->IDLE.
  - The pipeline advances past the store at the end of WRITE.
- Pipeline contract: Req, Op, Addr and StoreData are held stable while Busy=1.
- Reset mid-RMW (in WRITE): DmWe drops immediately, write abandoned, state IDLE, memory unchanged.
- LoadValid and AddrErr are never both 1.
- Stores never assert LoadValid.

Test Plan:
- Reset released, memory word 3 = 0x8899AABB; LB Addr=0x0000000D -> DmA=3, next cycle LoadValid=1, LoadData=0xFFFFFFAA; LBU same address -> 0x000000AA.
- LH Addr=0x0000000E on same word -> LoadData=0xFFFF8899; LHU -> 0x00008899; LW Addr=0x0000000C -> 0x8899AABB.
- SB Addr=0x0000000D StoreData=0x12345677 -> cycle 1: Busy=1, DmWe=0; cycle 2: DmWe=1, DmA=3, DmWD=0x8899 77BB (0x889977BB), Busy=0; LW readback = 0x889977BB.
- SW Addr=0x00000010 StoreData=0xDEADBEEF -> same-cycle DmWe=1, Busy=0; LH Addr=0x00000012 -> 0xFFFFDEAD.
- LW Addr=0x00000006 and SH Addr=0x00000005 -> DmWe=0 throughout, next cycle AddrErr=1, LoadValid=0, memory unchanged.
- SH Addr=0x00000010, Reset asserted during WRITE -> DmWe=0 immediately, outputs zero, LW Addr=0x10 after release -> 0xDEADBEEF.
